instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  PC register and next-PC logic feeding the single-cycle datapath's instruction memory.
//  - Drives instruction address into I_MEM (byte-addressed, big-endian, bit [0] = MSB).
//  - Resolves branch/jump targets from the current instruction plus decoder/regfile flags.
//  - Halts on TRAP 0x300 (instruction 32'h44000300) and counts retired instructions for the bench.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  TRAP_WORD   32'h4400_0300  end-of-program trap encoding
//  CNT_W       32             retired-instruction counter width
// PORTS
//  clock        in   1      single clock; all state updates on posedge
//  reset        in   1      asynchronous, active-high
//  instr_in     in   [0:31] instruction word read from I_MEM at instr_addr
//  stall        in   1      hold PC and counter this cycle (memory wait)
//  rs1_val      in   [0:31] regfile port-A value (branch test, JR/JALR target)
//  instr_addr   out  [0:31] current PC to I_MEM
//  link_addr    out  [0:31] instr_addr + 4, written to r31 by JAL/JALR
//  halted       out  1      high once trap retired; sticky until reset
//  retired_cnt  out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset (async assert, sync release): instr_addr=RESET_PC, halted=0, retired_cnt=0, state=RUN.
//  States: RUN, HALT.
//   RUN : on posedge, if !stall: PC <= next_pc, retired_cnt += 1.
//         if instr_in == TRAP_WORD and !stall: state->HALT, halted<=1, PC unchanged, cnt += 1.
//   HALT: PC, cnt frozen; stall ignored; leave only via reset.
//  Opcode = instr_in[0:5]; imm16 = instr_in[16:31]; imm26 = instr_in[6:31]. seq = PC+4.
//   0x02 J     next = seq + sext(imm26)
//   0x03 JAL   next = seq + sext(imm26)
//   0x04 BEQZ  next = (rs1_val==0) ? seq + sext(imm16) : seq
//   0x05 BNEZ  next = (rs1_val!=0) ? seq + sext(imm16) : seq
//   0x12 JR    next = rs1_val
//   0x13 JALR  next = rs1_val
//   other      next = seq (includes non-0x300 TRAP, treated as NOP)
//  Arithmetic: 32-bit, modulo 2^32; PC wraps 32'hFFFF_FFFC -> 0 silently.
//  next_pc[30:31] forced to 2'b00 (word alignment); misaligned JR target truncated, no fault.
//  retired_cnt saturates at all-ones; never wraps.
//  link_addr purely combinational from instr_addr; valid same cycle.
//  Branch/jump resolution combinational; zero-latency redirect (no delay slot).
//  stall and trap same cycle: stall wins; trap retires on first unstalled cycle.
//  reset asserted mid-cycle: outputs take reset values immediately, no clock needed.
// STRUCTURE
//  Shared package isa_pkg: opcode constants (OP_J, OP_JAL, OP_BEQZ, OP_BNEZ, OP_JR, OP_JALR,
//   OP_TRAP), TRAP_WORD, fetch-state enum {RUN, HALT}.
//  One sub-module: next_pc_calc (combinational target select: instr_in, PC, rs1_val -> next_pc).
//  PC/state/counter registers in this module.
// TESTING
//  1 reset pulse, NOP stream (32'h00000000) for 4 clocks -> instr_addr 0,4,8,12,16; retired_cnt=4.
//  2 PC=0x10, BEQZ imm16=0x0008, rs1_val=0 -> next 0x1C; rs1_val=5 -> next 0x14.
//  3 PC=0x40, J imm26=0x3FFFFF8 (-8) -> next 0x3C; JAL same -> link_addr=0x44 that cycle.
//  4 JR with rs1_val=0x0000_0103 -> next instr_addr 0x100 (low bits cleared).
//  5 trap 32'h44000300 at PC=0x20 with stall high 2 cycles -> PC holds 0x20, halted=0;
//    stall low -> halted=1, PC stays 0x20, cnt +1, then frozen 10 clocks with NOPs applied.
//  6 reset asserted between edges while halted -> instr_addr=RESET_PC, halted=0, cnt=0
//    before next posedge; fetch resumes after release.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding for the single-cycle datapath front end.
package isa_pkg;

   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQZ = 6'h04;
   localparam logic [5:0] OP_BNEZ = 6'h05;
   localparam logic [5:0] OP_TRAP = 6'h11;
   localparam logic [5:0] OP_JR   = 6'h12;
   localparam logic [5:0] OP_JALR = 6'h13;

   localparam logic [0:31] TRAP_WORD = 32'h4400_0300;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational branch/jump target select; bit 0 is the MSB throughout.
module next_pc_calc
   import isa_pkg::*;
(
   input  logic [0:31] instr_in,
   input  logic [0:31] pc,
   input  logic [0:31] rs1_val,
   output logic [0:31] next_pc
);

   logic [0:5]  opcode;
   logic [0:31] seq;
   logic [0:31] sext16;
   logic [0:31] sext26;
   logic [0:31] target;

   assign opcode = instr_in[0:5];
   assign seq    = pc + 32'd4;
   assign sext16 = {{16{instr_in[16]}}, instr_in[16:31]};
   assign sext26 = {{6{instr_in[6]}}, instr_in[6:31]};

   always_comb begin
      target = seq;
      case (opcode)
         OP_J, OP_JAL:     target = seq + sext26;
         OP_BEQZ:          target = (rs1_val == 32'd0) ? seq + sext16 : seq;
         OP_BNEZ:          target = (rs1_val != 32'd0) ? seq + sext16 : seq;
         OP_JR, OP_JALR:   target = rs1_val;
         default:          target = seq;
      endcase
   end

   // Misaligned targets are silently truncated to a word boundary.
   assign next_pc = {target[0:29], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, retire counter and RUN/HALT control for the instruction fetch stage.
module instr_fetch_unit
   import isa_pkg::*;
#(
   parameter logic [0:31] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [0:31]      instr_in,
   input  logic             stall,
   input  logic [0:31]      rs1_val,
   output logic [0:31]      instr_addr,
   output logic [0:31]      link_addr,
   output logic             halted,
   output logic [CNT_W-1:0] retired_cnt,
   output fetch_state_e     state
);

   // stall acts as an inverted ready: an instruction retires on a posedge only when
   // stall is low in RUN; while stall is high nothing advances, in HALT it is ignored.
   logic [0:31]      pc;
   logic [0:31]      pc_nxt;
   logic [0:31]      next_pc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   fetch_state_e     state_q;
   fetch_state_e     state_nxt;

   next_pc_calc u_next_pc_calc (
      .instr_in (instr_in),
      .pc       (pc),
      .rs1_val  (rs1_val),
      .next_pc  (next_pc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pc      <= RESET_PC;
         cnt     <= '0;
      end else begin
         state_q <= state_nxt;
         pc      <= pc_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      case (state_q)
         RUN: begin
            if (!stall) begin
               cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
               // The trap retires but leaves the PC pointing at itself.
               if (instr_in == TRAP_WORD) state_nxt = HALT;
               else                       pc_nxt    = next_pc;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign instr_addr  = pc;
   assign link_addr   = pc + 32'd4;
   assign halted      = (state_q == HALT);
   assign retired_cnt = cnt;
   assign state       = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: next-PC vector table plus reset/stall/trap sequences.
module tb_instr_fetch_unit;
   import isa_pkg::*;

   logic          clock;
   logic          reset;
   logic [0:31]   instr_in;
   logic          stall;
   logic [0:31]   rs1_val;
   logic [0:31]   instr_addr;
   logic [0:31]   link_addr;
   logic          halted;
   logic [31:0]   retired_cnt;
   fetch_state_e  state;

   logic [0:31]   sat_addr;
   logic [0:31]   sat_link;
   logic          sat_halted;
   logic [2:0]    sat_cnt;
   fetch_state_e  sat_state;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int exp_cnt   = 0;
   int sat_exp   = 0;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] exp_next;
      logic [31:0] exp_link;
   } vec_t;

   vec_t vecs[12];

   instr_fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .instr_in    (instr_in),
      .stall       (stall),
      .rs1_val     (rs1_val),
      .instr_addr  (instr_addr),
      .link_addr   (link_addr),
      .halted      (halted),
      .retired_cnt (retired_cnt),
      .state       (state)
   );

   // Narrow-counter instance fed a constant NOP stream to reach saturation quickly.
   instr_fetch_unit #(.CNT_W(3)) sat_dut (
      .clock       (clock),
      .reset       (reset),
      .instr_in    (32'h0000_0000),
      .stall       (1'b0),
      .rs1_val     (32'h0000_0000),
      .instr_addr  (sat_addr),
      .link_addr   (sat_link),
      .halted      (sat_halted),
      .retired_cnt (sat_cnt),
      .state       (sat_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // One posedge; the sat instance retires every cycle it is out of reset.
   task automatic tick();
      @(posedge clock);
      #1;
      if (!reset && sat_exp < 7) sat_exp++;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] r, input logic s);
      instr_in = i;
      rs1_val  = r;
      stall    = s;
   endtask

   initial begin
      vecs[0]  = '{"beqz_taken",    32'h10,       32'h1000_0008, 32'h0,     32'h1C,  32'h14};
      vecs[1]  = '{"beqz_not",      32'h10,       32'h1000_0008, 32'h5,     32'h14,  32'h14};
      vecs[2]  = '{"bnez_taken",    32'h10,       32'h1400_0008, 32'h5,     32'h1C,  32'h14};
      vecs[3]  = '{"bnez_not",      32'h10,       32'h1400_0008, 32'h0,     32'h14,  32'h14};
      vecs[4]  = '{"j_back",        32'h40,       32'h0BFF_FFF8, 32'h0,     32'h3C,  32'h44};
      vecs[5]  = '{"jal_back",      32'h40,       32'h0FFF_FFF8, 32'h0,     32'h3C,  32'h44};
      vecs[6]  = '{"jr_misalign",   32'h40,       32'h4800_0000, 32'h103,   32'h100, 32'h44};
      vecs[7]  = '{"jalr",          32'h200,      32'h4C00_0000, 32'h2002,  32'h2000,32'h204};
      vecs[8]  = '{"nop_wrap",      32'hFFFF_FFFC,32'h0000_0000, 32'h0,     32'h0,   32'h0};
      vecs[9]  = '{"beqz_neg",      32'h100,      32'h1000_FFF0, 32'h0,     32'hF4,  32'h104};
      vecs[10] = '{"trap_other",    32'h80,       32'h4400_0000, 32'h0,     32'h84,  32'h84};
      vecs[11] = '{"beqz_odd_imm",  32'h10,       32'h1000_0003, 32'h0,     32'h14,  32'h14};

      reset = 1'b1;
      drive(32'h0, 32'h0, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1;
      check("reset_addr",  instr_addr,  32'h0);
      check("reset_link",  link_addr,   32'h4);
      check("reset_halt",  {31'b0, halted}, 32'h0);
      check("reset_cnt",   retired_cnt, 32'h0);
      check("reset_state", {31'b0, state}, {31'b0, RUN});
      reset = 1'b0;

      // NOP stream: PC walks 0,4,8,12,16.
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_cnt++;
         check($sformatf("nop_addr_%0d", i), instr_addr, 32'(4 * i));
      end
      check("nop_cnt", retired_cnt, 32'd4);
      check("sat_cnt_4", {29'b0, sat_cnt}, 32'(sat_exp));

      // Vector table: steer PC with JR, then apply the instruction under test.
      for (int v = 0; v < 12; v++) begin
         drive(32'h4800_0000, vecs[v].pc, 1'b0);
         tick();
         exp_cnt++;
         check({vecs[v].name, "_setup"}, instr_addr, vecs[v].pc);
         drive(vecs[v].instr, vecs[v].rs1, 1'b0);
         @(negedge clock);
         check({vecs[v].name, "_link"}, link_addr, vecs[v].exp_link);
         tick();
         exp_cnt++;
         check({vecs[v].name, "_next"}, instr_addr, vecs[v].exp_next);
         check({vecs[v].name, "_sat"}, {29'b0, sat_cnt}, 32'(sat_exp));
      end
      check("table_cnt", retired_cnt, 32'(exp_cnt));

      // Trap held off by stall, then retires and freezes everything.
      drive(32'h4800_0000, 32'h20, 1'b0);
      tick();
      exp_cnt++;
      drive(TRAP_WORD, 32'h0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stall_addr", instr_addr, 32'h20);
         check("stall_halt", {31'b0, halted}, 32'h0);
         check("stall_cnt",  retired_cnt, 32'(exp_cnt));
      end
      stall = 1'b0;
      tick();
      exp_cnt++;
      check("trap_halt",  {31'b0, halted}, 32'h1);
      check("trap_state", {31'b0, state}, {31'b0, HALT});
      check("trap_addr",  instr_addr, 32'h20);
      check("trap_cnt",   retired_cnt, 32'(exp_cnt));
      for (int i = 0; i < 10; i++) begin
         drive(32'h0, 32'(i), 1'($urandom_range(0, 1)));
         tick();
      end
      check("frozen_addr", instr_addr, 32'h20);
      check("frozen_halt", {31'b0, halted}, 32'h1);
      check("frozen_cnt",  retired_cnt, 32'(exp_cnt));
      check("sat_cnt_max", {29'b0, sat_cnt}, 32'd7);

      // Asynchronous reset between edges while halted.
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("areset_addr",  instr_addr, 32'h0);
      check("areset_halt",  {31'b0, halted}, 32'h0);
      check("areset_cnt",   retired_cnt, 32'h0);
      check("areset_state", {31'b0, state}, {31'b0, RUN});
      check("areset_sat",   {29'b0, sat_cnt}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      sat_exp = 0;
      drive(32'h0, 32'h0, 1'b0);
      tick();
      check("resume_addr1", instr_addr, 32'h4);
      tick();
      check("resume_addr2", instr_addr, 32'h8);
      check("resume_cnt",   retired_cnt, 32'd2);
      check("resume_halt",  {31'b0, halted}, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
